// File: rtl/mul_seq_pkg.sv
// Shared constants and state encoding for the sequential MULT/MULTU unit.
// The control unit's stall logic uses MUL_LATENCY as well, so keep it in
// step with the FSM below.
package mul_seq_pkg;

    // Number of shift-add iterations; one multiplier bit is consumed per cycle
    localparam int ITER = 32;

    // Cycles from the start cycle to the done cycle: PREP + ITER x MUL + FIX + DONE
    localparam int MUL_LATENCY = 35;

    // Multiplier sequencer states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_MUL  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder without a carry-out port.
// Eight 4-bit lookahead groups; the group carries chain between groups.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = ci;

    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_grp
            localparam int B = 4 * k;

            assign c[B+1] = g[B] | (p[B] & c[B]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & c[B]);

            // The top group's carry-out would be bit 32, which this adder does not expose
            if (k < 7) begin : g_next
                logic grp_g;
                logic grp_p;

                assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
                assign grp_p = p[B+3] & p[B+2] & p[B+1] & p[B];
                assign c[B+4] = grp_g | (grp_p & c[B]);
            end
        end
    endgenerate

    assign s = p ^ c;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle 32x32 -> 64 multiplier for MULT/MULTU.
// Signed operands are reduced to magnitudes in PREP, multiplied unsigned by
// ITER shift-add steps in MUL, and the sign is reapplied in FIX. Only the
// FIX edge writes hi/lo, so an aborted or reset operation never leaks a
// partial product.
module mul_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = mul_seq_pkg::ITER
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mul_seq_pkg::*;

    localparam int CNT_W = $clog2(ITER);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             signed_r;
    logic             neg;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] cnt;

    logic [31:0]      add0_x;
    logic [31:0]      add0_y;
    logic             add0_ci;
    logic [31:0]      add0_s;
    logic [31:0]      add1_x;
    logic             add1_ci;
    logic [31:0]      add1_s;
    logic             co;
    logic             lo_zero;

    assign lo_zero = (acc_lo == '0);

    // The adder has no carry-out, so recover it from the operand and sum MSBs
    assign co = (add0_x[31] & add0_y[31]) | ((add0_x[31] | add0_y[31]) & ~add0_s[31]);

    // Route the two adders: magnitudes of a/b in PREP, accumulate in MUL,
    // 64-bit negation (low word on adder 0, high word on adder 1) in FIX
    always_comb begin
        add0_x  = '0;
        add0_y  = '0;
        add0_ci = 1'b0;
        add1_x  = '0;
        add1_ci = 1'b0;
        case (state)
            S_PREP: begin
                add0_x  = ~a_r;
                add0_ci = 1'b1;
                add1_x  = ~b_r;
                add1_ci = 1'b1;
            end
            S_MUL: begin
                add0_x = acc_hi;
                add0_y = acc_lo[0] ? mcand : '0;
            end
            S_FIX: begin
                add0_x  = ~acc_lo;
                add0_ci = 1'b1;
                add1_x  = ~acc_hi;
                add1_ci = lo_zero;
            end
            default: begin
            end
        endcase
    end

    cla32 u_add0 (
        .a  (add0_x),
        .b  (add0_y),
        .ci (add0_ci),
        .s  (add0_s)
    );

    cla32 u_add1 (
        .a  (add1_x),
        .b  ('0),
        .ci (add1_ci),
        .s  (add1_s)
    );

    // Sequencer, datapath registers and registered handshake outputs;
    // flush returns to IDLE without touching hi/lo and overrides start
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= S_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            signed_r <= 1'b0;
            neg      <= 1'b0;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        signed_r <= is_signed;
                        busy     <= 1'b1;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    mcand  <= (signed_r & a_r[WIDTH-1]) ? add0_s : a_r;
                    acc_lo <= (signed_r & b_r[WIDTH-1]) ? add1_s : b_r;
                    acc_hi <= '0;
                    neg    <= signed_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    cnt    <= '0;
                    state  <= S_MUL;
                end
                S_MUL: begin
                    acc_hi <= {co, add0_s[WIDTH-1:1]};
                    acc_lo <= {add0_s[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi    <= neg ? add1_s : acc_hi;
                    lo    <= neg ? add0_s : acc_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq: reset, unsigned and signed
// products, handshake timing, start while busy, flush and mid-run reset.
module tb_mul_seq;

    logic        clk;
    logic        clrn;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run;
    int tests_failed;

    mul_seq dut (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one operation from a negedge and wait (bounded) for done.
    // cycles = posedges from the start cycle until done is seen, 0 on timeout.
    task automatic apply_stimulus(input logic sgn, input logic [31:0] op_a,
                                  input logic [31:0] op_b,
                                  output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        a         = op_a;
        b         = op_b;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a     = 32'hDEAD_BEEF;
                b     = 32'h0BAD_F00D;
            end
            if (busy) busy_cycles++;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clrn = 1'b1;
        #2 clrn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_done: got %b want 0", done);
        end
        tests_run++;
        if ({hi, lo} !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hilo: got %h_%h want 0", hi, lo);
        end
        clrn = 1'b1;
    endtask

    task automatic test_multu_timing();
        int cyc;
        int bcyc;
        apply_stimulus(1'b0, 32'd7, 32'd6, cyc, bcyc);
        tests_run++;
        if (cyc !== 35) begin
            tests_failed++;
            $display("[TB] FAIL multu_7x6_latency: done after %0d edges want 35", cyc);
        end
        tests_run++;
        if (bcyc !== 34) begin
            tests_failed++;
            $display("[TB] FAIL multu_7x6_busy: busy %0d cycles want 34", bcyc);
        end
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'h0000_002A) begin
            tests_failed++;
            $display("[TB] FAIL multu_7x6: got %h_%h want 00000000_0000002a", hi, lo);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_products();
        logic        sgn [6];
        logic [31:0] va  [6];
        logic [31:0] vb  [6];
        logic [63:0] exp [6];
        int cyc;
        int bcyc;
        sgn[0] = 1'b0; va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; exp[0] = 64'hFFFF_FFFE_0000_0001;
        sgn[1] = 1'b1; va[1] = 32'hFFFF_FFFD; vb[1] = 32'd5;         exp[1] = 64'hFFFF_FFFF_FFFF_FFF1;
        sgn[2] = 1'b1; va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; exp[2] = 64'h4000_0000_0000_0000;
        sgn[3] = 1'b1; va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF; exp[3] = 64'h0000_0000_0000_0001;
        sgn[4] = 1'b0; va[4] = 32'h0000_0000; vb[4] = 32'h1234_5678; exp[4] = 64'h0;
        sgn[5] = 1'b1; va[5] = 32'd100;       vb[5] = 32'hFFFF_FFF9; exp[5] = 64'hFFFF_FFFF_FFFF_FD44;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(sgn[i], va[i], vb[i], cyc, bcyc);
            tests_run++;
            if (cyc !== 35 || {hi, lo} !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL product_%0d: got %h_%h after %0d edges want %h after 35",
                         i, hi, lo, cyc, exp[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        cyc = 0;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd5; b = 32'd5;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = (k == 10);
            a     = (k == 10) ? 32'd2 : 32'd0;
            b     = (k == 10) ? 32'd3 : 32'd0;
            if (done) begin
                cyc = k;
                break;
            end
        end
        start = 1'b0;
        tests_run++;
        if (cyc !== 35 || hi !== 32'h0 || lo !== 32'd25) begin
            tests_failed++;
            $display("[TB] FAIL start_while_busy: got %h_%h after %0d edges want 0_25 after 35",
                     hi, lo, cyc);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ignored_start_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_flush();
        bit saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd4; b = 32'd4;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        tests_run++;
        if (busy !== 1'b1 || lo !== 32'd25) begin
            tests_failed++;
            $display("[TB] FAIL mid_run_hold: busy=%b lo=%0d want 1 25", busy, lo);
        end
        flush = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_busy: got %b want 0", busy);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_no_done: activity seen=%b want 0", saw_done);
        end
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'd25) begin
            tests_failed++;
            $display("[TB] FAIL flush_hilo: got %h_%h want 0_25", hi, lo);
        end
    endtask

    task automatic test_clrn_mid();
        int cyc;
        int bcyc;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        clrn = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL clrn_mid: busy=%b done=%b hilo=%h_%h want 0 0 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        clrn = 1'b1;
        apply_stimulus(1'b0, 32'd9, 32'd9, cyc, bcyc);
        tests_run++;
        if (cyc !== 35 || hi !== 32'h0 || lo !== 32'h51) begin
            tests_failed++;
            $display("[TB] FAIL after_clrn_9x9: got %h_%h after %0d edges want 0_51 after 35",
                     hi, lo, cyc);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clrn         = 1'b1;
        start        = 1'b0;
        is_signed    = 1'b0;
        a            = '0;
        b            = '0;
        flush        = 1'b0;
        test_reset();
        test_multu_timing();
        test_products();
        test_start_while_busy();
        test_flush();
        test_clrn_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
